// File: rtl/rv_lsu_pkg.sv
// Shared types and encodings for the rv32i load/store unit (rv_lsu).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv_lsu_pkg;

    localparam int XLEN       = 32;
    localparam int DMEM_A_BIT = 8;

    // dmem byte-control encodings (match the load funct3 values)
    localparam logic [2:0] DMEM_BYTECTRL_BYTE  = 3'b000;
    localparam logic [2:0] DMEM_BYTECTRL_HALF  = 3'b001;
    localparam logic [2:0] DMEM_BYTECTRL_WORD  = 3'b010;
    localparam logic [2:0] DMEM_BYTECTRL_BYTEU = 3'b100;
    localparam logic [2:0] DMEM_BYTECTRL_HALFU = 3'b101;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] LSU_F3_LB  = 3'b000;
    localparam logic [2:0] LSU_F3_LH  = 3'b001;
    localparam logic [2:0] LSU_F3_LW  = 3'b010;
    localparam logic [2:0] LSU_F3_LBU = 3'b100;
    localparam logic [2:0] LSU_F3_LHU = 3'b101;
    localparam logic [2:0] LSU_F3_SB  = 3'b000;
    localparam logic [2:0] LSU_F3_SH  = 3'b001;
    localparam logic [2:0] LSU_F3_SW  = 3'b010;

    // Split-access FSM states
    typedef enum logic {
        LSU_ST_IDLE   = 1'b0,
        LSU_ST_SPLIT2 = 1'b1
    } lsu_st_t;

    // Access classification by size and byte offset
    typedef enum logic [1:0] {
        ACC_ALIGNED = 2'd0,
        ACC_INWORD  = 2'd1,
        ACC_CROSS   = 2'd2
    } acc_cls_t;

    // Bytes always fit; halves at off 1 stay in the word, at off 3 they cross;
    // words (and unused size code 11) cross at any non-zero offset.
    function automatic acc_cls_t lsu_classify(input logic [2:0] funct3, input logic [1:0] off);
        acc_cls_t cls;
        cls = ACC_ALIGNED;
        case (funct3[1:0])
            2'b00: cls = ACC_ALIGNED;
            2'b01: begin
                if (off == 2'b01)      cls = ACC_INWORD;
                else if (off == 2'b11) cls = ACC_CROSS;
                else                   cls = ACC_ALIGNED;
            end
            default: cls = (off == 2'b00) ? ACC_ALIGNED : ACC_CROSS;
        endcase
        return cls;
    endfunction

    // Aligned accesses let dmem do its own lane select and extension
    function automatic logic [2:0] lsu_bytectrl(input logic [2:0] funct3);
        logic [2:0] bc;
        case (funct3)
            LSU_F3_LB:  bc = DMEM_BYTECTRL_BYTE;
            LSU_F3_LH:  bc = DMEM_BYTECTRL_HALF;
            LSU_F3_LBU: bc = DMEM_BYTECTRL_BYTEU;
            LSU_F3_LHU: bc = DMEM_BYTECTRL_HALFU;
            default:    bc = DMEM_BYTECTRL_WORD;
        endcase
        return bc;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane merge (store) and extract/extend (load) for misaligned accesses.
// Latency: purely combinational.
// Backpressure: none; follows the caller's phase input.
module rv_lsu_align
    import rv_lsu_pkg::*;
(
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] lo_q,
    input  logic            phase,
    output logic [XLEN-1:0] wr_word,
    output logic [XLEN-1:0] ld_val
);

    logic [4:0]        sh;
    logic [XLEN-1:0]   size_mask;
    logic [2*XLEN-1:0] lane_mask;
    logic [2*XLEN-1:0] ins;
    logic [2*XLEN-1:0] cat;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   raw;

    assign sh = {off, 3'b000};

    // Treat the two touched words as one 64-bit window: phase 0 owns the low
    // word, phase 1 the high word, so one shift serves both split halves.
    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        lane_mask = {{XLEN{1'b0}}, size_mask} << sh;
        ins       = {{XLEN{1'b0}}, wd & size_mask} << sh;
        lane      = phase ? lane_mask[2*XLEN-1:XLEN] : lane_mask[XLEN-1:0];
        wr_word   = (word & ~lane) | (phase ? ins[2*XLEN-1:XLEN] : ins[XLEN-1:0]);

        cat = phase ? {word, lo_q} : {{XLEN{1'b0}}, word};
        raw = cat[sh +: XLEN];
        case (funct3)
            LSU_F3_LB:  ld_val = {{24{raw[7]}}, raw[7:0]};
            LSU_F3_LBU: ld_val = {24'b0, raw[7:0]};
            LSU_F3_LH:  ld_val = {{16{raw[15]}}, raw[15:0]};
            LSU_F3_LHU: ld_val = {16'b0, raw[15:0]};
            default:    ld_val = raw;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// MEM-stage load/store unit driving rv_dmem; LSU_MISALIGN_SPLIT_EN builds the split FSM, else misaligned accesses trap.
// Latency: aligned/inword results combinational in the request cycle; word-crossing accesses take 2 cycles.
// Backpressure: o_lsu_stall high for the first cycle of a crossing access; upstream holds its inputs meanwhile.
module rv_lsu
    import rv_lsu_pkg::*;
(
    input  logic                  i_lsu_clk,
    input  logic                  i_lsu_rstn,
    input  logic                  i_lsu_valid,
    input  logic                  i_lsu_we,
    input  logic [2:0]            i_lsu_funct3,
    input  logic [XLEN-1:0]       i_lsu_addr,
    input  logic [XLEN-1:0]       i_lsu_wd,
    output logic [XLEN-1:0]       o_lsu_rd,
    output logic                  o_lsu_stall,
    output logic                  o_lsu_misalign,
    output logic [DMEM_A_BIT-1:0] o_lsu_dmem_a,
    output logic [XLEN-1:0]       o_lsu_dmem_wd,
    output logic                  o_lsu_dmem_we,
    output logic [2:0]            o_lsu_dmem_bytectrl,
    input  logic [XLEN-1:0]       i_lsu_dmem_rd
);

    logic [1:0]            off;
    logic [DMEM_A_BIT-1:0] a_byte;
    acc_cls_t              cls;

    assign off    = i_lsu_addr[1:0];
    assign a_byte = i_lsu_addr[DMEM_A_BIT-1:0];
    assign cls    = lsu_classify(i_lsu_funct3, off);

`ifdef LSU_MISALIGN_SPLIT_EN

    localparam logic [DMEM_A_BIT-3:0] WIDX_ONE = 1;

    lsu_st_t               state;
    logic [XLEN-1:0]       lo_q;
    logic [DMEM_A_BIT-1:0] w0;
    logic [DMEM_A_BIT-1:0] w1;
    logic                  phase;
    logic [XLEN-1:0]       wr_word;
    logic [XLEN-1:0]       ld_val;
    logic                  unused_addr;

    // Upper address bits lie outside dmem and are ignored
    assign unused_addr = ^i_lsu_addr[XLEN-1:DMEM_A_BIT];

    // w1 wraps inside dmem, so the last word is followed by word 0
    assign w0    = {a_byte[DMEM_A_BIT-1:2], 2'b00};
    assign w1    = {a_byte[DMEM_A_BIT-1:2] + WIDX_ONE, 2'b00};
    assign phase = (state == LSU_ST_SPLIT2);

    assign o_lsu_misalign = 1'b0;

    rv_lsu_align u_align (
        .off     (off),
        .funct3  (i_lsu_funct3),
        .wd      (i_lsu_wd),
        .word    (i_lsu_dmem_rd),
        .lo_q    (lo_q),
        .phase   (phase),
        .wr_word (wr_word),
        .ld_val  (ld_val)
    );

    // Split FSM: a crossing request parks the low word and moves to SPLIT2 for exactly one cycle
    always_ff @(posedge i_lsu_clk) begin
        if (!i_lsu_rstn) begin
            state <= LSU_ST_IDLE;
            lo_q  <= '0;
        end else begin
            case (state)
                LSU_ST_IDLE: begin
                    if (i_lsu_valid && (cls == ACC_CROSS)) begin
                        if (!i_lsu_we) lo_q <= i_lsu_dmem_rd;
                        state <= LSU_ST_SPLIT2;
                    end
                end
                default: state <= LSU_ST_IDLE;
            endcase
        end
    end

    // dmem muxing: SPLIT2 always targets w1; IDLE targets addr (aligned) or w0 (inword / first half)
    always_comb begin
        o_lsu_dmem_a        = a_byte;
        o_lsu_dmem_wd       = i_lsu_wd;
        o_lsu_dmem_we       = 1'b0;
        o_lsu_dmem_bytectrl = lsu_bytectrl(i_lsu_funct3);
        o_lsu_rd            = '0;
        o_lsu_stall         = 1'b0;
        if (state == LSU_ST_SPLIT2) begin
            o_lsu_dmem_a        = w1;
            o_lsu_dmem_bytectrl = DMEM_BYTECTRL_WORD;
            o_lsu_dmem_wd       = wr_word;
            if (i_lsu_valid) begin
                o_lsu_dmem_we = i_lsu_we;
                o_lsu_rd      = ld_val;
            end
        end else if (i_lsu_valid) begin
            case (cls)
                ACC_ALIGNED: begin
                    o_lsu_dmem_we = i_lsu_we;
                    o_lsu_rd      = i_lsu_dmem_rd;
                end
                ACC_INWORD: begin
                    o_lsu_dmem_a        = w0;
                    o_lsu_dmem_bytectrl = DMEM_BYTECTRL_WORD;
                    o_lsu_dmem_wd       = wr_word;
                    o_lsu_dmem_we       = i_lsu_we;
                    o_lsu_rd            = ld_val;
                end
                default: begin
                    o_lsu_dmem_a        = w0;
                    o_lsu_dmem_bytectrl = DMEM_BYTECTRL_WORD;
                    o_lsu_dmem_wd       = wr_word;
                    o_lsu_dmem_we       = i_lsu_we;
                    o_lsu_stall         = 1'b1;
                end
            endcase
        end
        if (!i_lsu_rstn) begin
            o_lsu_dmem_we = 1'b0;
            o_lsu_stall   = 1'b0;
            o_lsu_rd      = '0;
        end
    end

`else

    logic unused_in;

    // Clock and upper address bits have no use without the split FSM
    assign unused_in = ^{i_lsu_addr[XLEN-1:DMEM_A_BIT], i_lsu_clk};

    assign o_lsu_stall = 1'b0;

    // Aligned pass-through; anything misaligned is flagged for the trap logic and suppressed
    always_comb begin
        o_lsu_dmem_a        = a_byte;
        o_lsu_dmem_wd       = i_lsu_wd;
        o_lsu_dmem_we       = 1'b0;
        o_lsu_dmem_bytectrl = lsu_bytectrl(i_lsu_funct3);
        o_lsu_rd            = '0;
        o_lsu_misalign      = 1'b0;
        if (i_lsu_valid) begin
            if (cls == ACC_ALIGNED) begin
                o_lsu_dmem_we = i_lsu_we;
                o_lsu_rd      = i_lsu_dmem_rd;
            end else begin
                o_lsu_misalign = 1'b1;
            end
        end
        if (!i_lsu_rstn) begin
            o_lsu_dmem_we  = 1'b0;
            o_lsu_misalign = 1'b0;
            o_lsu_rd       = '0;
        end
    end

`endif

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu with a byte-addressed dmem model and an expected-result queue.
// Latency: expects 1 cycle for aligned/inword and 2 cycles for crossing accesses (split build).
// Backpressure: holds request inputs while o_lsu_stall is high, bounded to 4 cycles.
module tb_rv_lsu;
    import rv_lsu_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  valid;
    logic                  we;
    logic [2:0]            f3;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       wd;
    logic [XLEN-1:0]       rd;
    logic                  stall;
    logic                  mis;
    logic [DMEM_A_BIT-1:0] dmem_a;
    logic [XLEN-1:0]       dmem_wd;
    logic                  dmem_we;
    logic [2:0]            bc;
    logic [XLEN-1:0]       dmem_rd;

    logic [7:0] mem [256];
    logic [7:0] rb0, rb1, rb2, rb3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rd;
        int          cyc;
        logic        mis;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rv_lsu dut (
        .i_lsu_clk           (clk),
        .i_lsu_rstn          (rstn),
        .i_lsu_valid         (valid),
        .i_lsu_we            (we),
        .i_lsu_funct3        (f3),
        .i_lsu_addr          (addr),
        .i_lsu_wd            (wd),
        .o_lsu_rd            (rd),
        .o_lsu_stall         (stall),
        .o_lsu_misalign      (mis),
        .o_lsu_dmem_a        (dmem_a),
        .o_lsu_dmem_wd       (dmem_wd),
        .o_lsu_dmem_we       (dmem_we),
        .o_lsu_dmem_bytectrl (bc),
        .i_lsu_dmem_rd       (dmem_rd)
    );

    // dmem model: combinational read with lane select/extension, write on the clock edge
    assign rb0 = mem[dmem_a];
    assign rb1 = mem[dmem_a + 8'd1];
    assign rb2 = mem[dmem_a + 8'd2];
    assign rb3 = mem[dmem_a + 8'd3];

    always_comb begin
        case (bc)
            DMEM_BYTECTRL_BYTE:  dmem_rd = {{24{rb0[7]}}, rb0};
            DMEM_BYTECTRL_BYTEU: dmem_rd = {24'b0, rb0};
            DMEM_BYTECTRL_HALF:  dmem_rd = {{16{rb1[7]}}, rb1, rb0};
            DMEM_BYTECTRL_HALFU: dmem_rd = {16'b0, rb1, rb0};
            default:             dmem_rd = {rb3, rb2, rb1, rb0};
        endcase
    end

    always @(posedge clk) begin
        if (dmem_we) begin
            mem[dmem_a] <= dmem_wd[7:0];
            if (bc[1:0] != 2'b00) mem[dmem_a + 8'd1] <= dmem_wd[15:8];
            if (bc[1:0] == 2'b10) begin
                mem[dmem_a + 8'd2] <= dmem_wd[23:16];
                mem[dmem_a + 8'd3] <= dmem_wd[31:24];
            end
        end
    end

    function automatic logic [31:0] mword(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One request: push the expectation, hold inputs through any stall, compare on the result cycle
    task automatic access(input logic w, input logic [2:0] fn, input logic [31:0] ad,
                          input logic [31:0] d, input logic [31:0] erd, input int ecyc,
                          input logic emis, input string tag);
        exp_t e;
        int   cyc;
        e.rd  = erd;
        e.cyc = ecyc;
        e.mis = emis;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b1; we = w; f3 = fn; addr = ad; wd = d;
        cyc = 1;
        @(negedge clk);
        while (stall === 1'b1 && cyc < 4) begin
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        if (!w) chk({tag, "_rd"}, rd, e.rd);
        chk({tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
        chk({tag, "_mis"}, {31'b0, mis}, {31'b0, e.mis});
        chk({tag, "_we"}, {31'b0, dmem_we}, {31'b0, w & ~e.mis});
        @(posedge clk);
        #1;
        valid = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h4433_2211;
        {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]} = 32'h8877_6655;
        {mem[8'h1B], mem[8'h1A], mem[8'h19], mem[8'h18]} = 32'hC3B2_A190;
        {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'hDEAD_BEEF;
        {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'hBBAA_9988;
        {mem[8'h03], mem[8'h02], mem[8'h01], mem[8'h00]} = 32'h3322_1100;

        // Reset: outputs forced low even with a valid request present
        rstn = 1'b0; valid = 1'b1; we = 1'b0; f3 = LSU_F3_LW; addr = 32'h10; wd = '0;
        @(negedge clk);
        chk("rst_rd", rd, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        addr = 32'h11;
        #1;
        chk("rst_mis", {31'b0, mis}, 32'h0);
        chk("rst_stall_cross", {31'b0, stall}, 32'h0);
        we = 1'b1; f3 = LSU_F3_SW; addr = 32'h20; wd = 32'h1111_1111;
        #1;
        chk("rst_we", {31'b0, dmem_we}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_nowrite", mword(8'h20), 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        rstn = 1'b1; valid = 1'b0; we = 1'b0; f3 = LSU_F3_LW; addr = 32'h10;
        @(negedge clk);
        chk("idle_rd", rd, 32'h0);
        chk("idle_we", {31'b0, dmem_we}, 32'h0);
        chk("idle_stall", {31'b0, stall}, 32'h0);

        // Aligned loads
        access(1'b0, LSU_F3_LW,  32'h10, 0, 32'h4433_2211, 1, 1'b0, "lw10");
        access(1'b0, LSU_F3_LW,  32'h14, 0, 32'h8877_6655, 1, 1'b0, "lw14");
        access(1'b0, LSU_F3_LB,  32'h17, 0, 32'hFFFF_FF88, 1, 1'b0, "lb17");
        access(1'b0, LSU_F3_LBU, 32'h17, 0, 32'h0000_0088, 1, 1'b0, "lbu17");
        access(1'b0, LSU_F3_LB,  32'h11, 0, 32'h0000_0022, 1, 1'b0, "lb11");
        access(1'b0, LSU_F3_LH,  32'h16, 0, 32'hFFFF_8877, 1, 1'b0, "lh16");
        access(1'b0, LSU_F3_LHU, 32'h16, 0, 32'h0000_8877, 1, 1'b0, "lhu16");
        access(1'b0, LSU_F3_LH,  32'h14, 0, 32'h0000_6655, 1, 1'b0, "lh14");

        // Aligned stores
        access(1'b1, LSU_F3_SH, 32'h22, 32'h0000_1234, 0, 1, 1'b0, "sh22");
        chk("sh22_mem", mword(8'h20), 32'h1234_BEEF);
        access(1'b1, LSU_F3_SB, 32'h21, 32'h0000_005A, 0, 1, 1'b0, "sb21");
        chk("sb21_mem", mword(8'h20), 32'h1234_5AEF);
        access(1'b1, LSU_F3_SW, 32'h24, 32'hCAFE_F00D, 0, 1, 1'b0, "sw24");
        chk("sw24_mem", mword(8'h24), 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Inword and crossing loads
        access(1'b0, LSU_F3_LW,  32'h11, 0, 32'h5544_3322, 2, 1'b0, "lw11");
        access(1'b0, LSU_F3_LW,  32'h13, 0, 32'h7766_5544, 2, 1'b0, "lw13");
        access(1'b0, LSU_F3_LH,  32'h11, 0, 32'h0000_3322, 1, 1'b0, "lh11");
        access(1'b0, LSU_F3_LH,  32'h13, 0, 32'h0000_5544, 2, 1'b0, "lh13");
        access(1'b0, LSU_F3_LH,  32'h19, 0, 32'hFFFF_B2A1, 1, 1'b0, "lh19");
        access(1'b0, LSU_F3_LHU, 32'h19, 0, 32'h0000_B2A1, 1, 1'b0, "lhu19");
        access(1'b0, LSU_F3_LH,  32'h17, 0, 32'hFFFF_9088, 2, 1'b0, "lh17");
        access(1'b0, LSU_F3_LHU, 32'h17, 0, 32'h0000_9088, 2, 1'b0, "lhu17");

        // Reset during the first cycle of a crossing store: nothing written, FSM idle afterwards
        @(posedge clk);
        #1;
        valid = 1'b1; we = 1'b1; f3 = LSU_F3_SW; addr = 32'h13; wd = 32'h9988_7766; rstn = 1'b0;
        @(negedge clk);
        chk("rst1_we", {31'b0, dmem_we}, 32'h0);
        chk("rst1_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1; we = 1'b0; f3 = LSU_F3_LW; addr = 32'h10;
        @(negedge clk);
        chk("rst1_idle_rd", rd, 32'h4433_2211);
        chk("rst1_idle_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("rst1_w0", mword(8'h10), 32'h4433_2211);
        chk("rst1_w1", mword(8'h14), 32'h8877_6655);

        // Reset in SPLIT2: first write stays, second is aborted
        @(posedge clk);
        #1;
        valid = 1'b1; we = 1'b1; f3 = LSU_F3_SW; addr = 32'h13; wd = 32'h0000_00EE;
        @(negedge clk);
        chk("rst2_stall", {31'b0, stall}, 32'h1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("rst2_we", {31'b0, dmem_we}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1; valid = 1'b0; we = 1'b0;
        chk("rst2_w0", mword(8'h10), 32'hEE33_2211);
        chk("rst2_w1", mword(8'h14), 32'h8877_6655);

        // Crossing and inword stores
        access(1'b1, LSU_F3_SW, 32'h12, 32'hAABB_CCDD, 0, 2, 1'b0, "sw12");
        chk("sw12_w0", mword(8'h10), 32'hCCDD_2211);
        chk("sw12_w1", mword(8'h14), 32'h8877_AABB);
        access(1'b1, LSU_F3_SH, 32'h11, 32'h0000_1234, 0, 1, 1'b0, "sh11");
        chk("sh11_w0", mword(8'h10), 32'hCC12_3411);
        chk("sh11_w1", mword(8'h14), 32'h8877_AABB);

        // Wrap from the last dmem word to word 0
        access(1'b0, LSU_F3_LW, 32'hFD, 0, 32'h00BB_AA99, 2, 1'b0, "lwFD");
        access(1'b1, LSU_F3_SW, 32'hFE, 32'h1234_5678, 0, 2, 1'b0, "swFE");
        chk("swFE_w0", mword(8'hFC), 32'h5678_9988);
        chk("swFE_w1", mword(8'h00), 32'h3322_1234);
`else
        // Misaligned accesses are flagged and suppressed
        access(1'b0, LSU_F3_LW,  32'h11, 0, 32'h0, 1, 1'b1, "mis_lw11");
        access(1'b0, LSU_F3_LH,  32'h11, 0, 32'h0, 1, 1'b1, "mis_lh11");
        access(1'b0, LSU_F3_LHU, 32'h13, 0, 32'h0, 1, 1'b1, "mis_lhu13");
        access(1'b0, LSU_F3_LW,  32'hFD, 0, 32'h0, 1, 1'b1, "mis_lwFD");
        access(1'b1, LSU_F3_SW,  32'h12, 32'hAABB_CCDD, 0, 1, 1'b1, "mis_sw12");
        chk("mis_sw12_w0", mword(8'h10), 32'h4433_2211);
        chk("mis_sw12_w1", mword(8'h14), 32'h8877_6655);
        access(1'b1, LSU_F3_SH,  32'h11, 32'h0000_1234, 0, 1, 1'b1, "mis_sh11");
        chk("mis_sh11_w0", mword(8'h10), 32'h4433_2211);
`endif

        // Aligned access after the misaligned traffic still behaves
        access(1'b0, LSU_F3_LW, 32'h24, 0, 32'hCAFE_F00D, 1, 1'b0, "lw24");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
